// File: rtl/axil_slave_mem.sv
// AXI4-Lite slave word memory with write/read commit counters.
// Optional: `define AXIL_SLAVE_MEM_SLVERR_EN makes out-of-range word indices answer SLVERR instead of aliasing.
module axil_slave_mem #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int NUM_WORDS          = 16,
    parameter int CNT_WIDTH          = 16
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [CNT_WIDTH-1:0]            wr_cnt,
    output logic [CNT_WIDTH-1:0]            rd_cnt
);
    localparam int RAW_W = C_S_AXI_ADDR_WIDTH - 2;
    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    typedef enum logic [2:0] {
        W_IDLE    = 3'd0,
        W_HAVE_AW = 3'd1,
        W_HAVE_W  = 3'd2,
        W_COMMIT  = 3'd3,
        W_RESP    = 3'd4
    } wstate_t;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_RESP = 1'b1
    } rstate_t;

    function automatic logic [IDX_W-1:0] map_idx(input logic [RAW_W-1:0] raw);
        return IDX_W'(32'(raw) % 32'(NUM_WORDS));
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return res;
    endfunction

    wstate_t                wstate_r, wstate_s;
    rstate_t                rstate_r, rstate_s;
    logic                   awready_r, awready_s, wready_r, wready_s, bvalid_r;
    logic                   arready_r, arready_s, rvalid_r;
    logic [1:0]             bresp_r, rresp_r;
    logic [31:0]            rdata_r, wdata_r;
    logic [3:0]             wstrb_r;
    logic [RAW_W-1:0]       aw_raw_r, ar_raw_s;
    logic [IDX_W-1:0]       aw_idx_s, ar_idx_s;
    logic [CNT_WIDTH-1:0]   wr_cnt_r, rd_cnt_r;
    logic [31:0]            mem_r [NUM_WORDS];
    logic [NUM_WORDS-1:0]   valid_r;
    logic [31:0]            old_word_s, rd_word_s;
    logic                   aw_hs_s, w_hs_s, ar_hs_s, commit_s, aw_ok_s, ar_ok_s;
    logic                   unused_s;

    assign aw_hs_s    = S_AXI_AWVALID & awready_r;
    assign w_hs_s     = S_AXI_WVALID & wready_r;
    assign ar_hs_s    = S_AXI_ARVALID & arready_r;
    assign commit_s   = (wstate_r == W_COMMIT);
    assign aw_idx_s   = map_idx(aw_raw_r);
    assign ar_raw_s   = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign ar_idx_s   = map_idx(ar_raw_s);
    // Words never written since reset read as zero; this is how reset clears memory.
    assign old_word_s = valid_r[aw_idx_s] ? mem_r[aw_idx_s] : 32'h0000_0000;
    assign rd_word_s  = valid_r[ar_idx_s] ? mem_r[ar_idx_s] : 32'h0000_0000;
    assign unused_s   = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

`ifdef AXIL_SLAVE_MEM_SLVERR_EN
    assign aw_ok_s = (32'(aw_raw_r) < 32'(NUM_WORDS));
    assign ar_ok_s = (32'(ar_raw_s) < 32'(NUM_WORDS));
`else
    assign aw_ok_s = 1'b1;
    assign ar_ok_s = 1'b1;
`endif

    // Write FSM next state and next-cycle ready values.
    always_comb begin
        wstate_s = wstate_r;
        case (wstate_r)
            W_IDLE: begin
                if (aw_hs_s && w_hs_s) begin
                    wstate_s = W_COMMIT;
                end else if (aw_hs_s) begin
                    wstate_s = W_HAVE_AW;
                end else if (w_hs_s) begin
                    wstate_s = W_HAVE_W;
                end else begin
                    wstate_s = W_IDLE;
                end
            end
            W_HAVE_AW: wstate_s = w_hs_s ? W_COMMIT : W_HAVE_AW;
            W_HAVE_W:  wstate_s = aw_hs_s ? W_COMMIT : W_HAVE_W;
            W_COMMIT:  wstate_s = W_RESP;
            W_RESP:    wstate_s = (bvalid_r && S_AXI_BREADY) ? W_IDLE : W_RESP;
            default:   wstate_s = W_IDLE;
        endcase
        awready_s = (wstate_s == W_IDLE) || (wstate_s == W_HAVE_W);
        wready_s  = (wstate_s == W_IDLE) || (wstate_s == W_HAVE_AW);
    end

    // Write channel registers, commit bookkeeping and write response.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            wstate_r  <= W_IDLE;
            awready_r <= 1'b0;
            wready_r  <= 1'b0;
            bvalid_r  <= 1'b0;
            bresp_r   <= 2'b00;
            aw_raw_r  <= '0;
            wdata_r   <= 32'h0000_0000;
            wstrb_r   <= 4'h0;
            wr_cnt_r  <= '0;
            valid_r   <= '0;
        end else begin
            wstate_r  <= wstate_s;
            awready_r <= awready_s;
            wready_r  <= wready_s;
            if (aw_hs_s) begin
                aw_raw_r <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
            end
            if (w_hs_s) begin
                wdata_r <= S_AXI_WDATA[31:0];
                wstrb_r <= S_AXI_WSTRB[3:0];
            end
            if (commit_s) begin
                if (aw_ok_s) begin
                    valid_r[aw_idx_s] <= 1'b1;
                end
                wr_cnt_r <= wr_cnt_r + CNT_WIDTH'(1);
                bvalid_r <= 1'b1;
                bresp_r  <= aw_ok_s ? 2'b00 : 2'b10;
            end else if (bvalid_r && S_AXI_BREADY) begin
                bvalid_r <= 1'b0;
            end
        end
    end

    // Memory array without reset so it can map onto RAM; valid_r masks stale contents.
    always_ff @(posedge ACLK) begin
        if (ARESETN && commit_s && aw_ok_s) begin
            mem_r[aw_idx_s] <= merge_bytes(old_word_s, wdata_r, wstrb_r);
        end
    end

    // Read FSM next state and next-cycle ARREADY.
    always_comb begin
        rstate_s = rstate_r;
        case (rstate_r)
            R_IDLE:  rstate_s = ar_hs_s ? R_RESP : R_IDLE;
            R_RESP:  rstate_s = (rvalid_r && S_AXI_RREADY) ? R_IDLE : R_RESP;
            default: rstate_s = R_IDLE;
        endcase
        arready_s = (rstate_s == R_IDLE);
    end

    // Read capture; a capture coinciding with a commit sees the pre-write word.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            rstate_r  <= R_IDLE;
            arready_r <= 1'b0;
            rvalid_r  <= 1'b0;
            rdata_r   <= 32'h0000_0000;
            rresp_r   <= 2'b00;
            rd_cnt_r  <= '0;
        end else begin
            rstate_r  <= rstate_s;
            arready_r <= arready_s;
            if (ar_hs_s) begin
                rdata_r  <= ar_ok_s ? rd_word_s : 32'hDEAD_BEEF;
                rresp_r  <= ar_ok_s ? 2'b00 : 2'b10;
                rvalid_r <= 1'b1;
                rd_cnt_r <= rd_cnt_r + CNT_WIDTH'(1);
            end else if (rvalid_r && S_AXI_RREADY) begin
                rvalid_r <= 1'b0;
            end
        end
    end

    assign S_AXI_AWREADY = awready_r;
    assign S_AXI_WREADY  = wready_r;
    assign S_AXI_BVALID  = bvalid_r;
    assign S_AXI_BRESP   = bresp_r;
    assign S_AXI_ARREADY = arready_r;
    assign S_AXI_RVALID  = rvalid_r;
    assign S_AXI_RDATA   = C_S_AXI_DATA_WIDTH'(rdata_r);
    assign S_AXI_RRESP   = rresp_r;
    assign wr_cnt        = wr_cnt_r;
    assign rd_cnt        = rd_cnt_r;

endmodule
